// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: splits one request into MEM_BYTES-wide memctrl beats and reassembles loads.
// Optional misaligned-access trap: define MEM_LSU_MISALIGN_TRAP_EN (adds resp_misalign).
module mem_lsu #(
  parameter int ADDR_W       = 32,
  parameter int MEM_BYTES    = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_load,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [4:0]             req_rd,
  output logic                   resp_valid,
  output logic                   resp_we,
  output logic [4:0]             resp_rd,
  output logic [31:0]            resp_data,
`ifdef MEM_LSU_MISALIGN_TRAP_EN
  output logic                   resp_misalign,
`endif
  output logic                   stall_o,
  output logic [1:0]             mem_rw,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [8*MEM_BYTES-1:0] mem_wdata,
  output logic [MEM_BYTES-1:0]   mem_wmask,
  input  logic                   mem_busy,
  input  logic [8*MEM_BYTES-1:0] mem_rdata
);
  localparam int STAGES = READ_LATENCY - 1;
  localparam int MW     = 8 * MEM_BYTES;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic              load;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [4:0]        rd;
  } req_t;

  req_t                  rq;
  logic [1:0]            state;
  logic [2:0]            beat, sz, nb;
  logic [31:0]           asm_q, ext, wshift, rd_ext, cap_mask;
  logic                  mis_q, mis_in, acc, last_beat, cap, done;
  logic [7:0]            cap_sh, wr_sh;
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:0][2:0]  idx_pipe;

  always_comb begin
    case (rq.size)
      2'b00:   sz = 3'd1;
      2'b01:   sz = 3'd2;
      default: sz = 3'd4;
    endcase
    nb = 3'((int'(sz) + MEM_BYTES - 1) / MEM_BYTES);
  end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign mis_in = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
  assign resp_misalign = done && mis_q;
`else
  assign mis_in = 1'b0;
`endif

  assign done      = (state == DONE);
  assign acc       = (state == ISSUE) && !mem_busy;
  assign last_beat = (beat == nb - 3'd1);

  // each accepted read beat carries its index down a latency pipe so beats can overlap
  assign cap      = vld_pipe[STAGES];
  assign cap_sh   = 8'(idx_pipe[STAGES]) * 8'(MW);
  assign rd_ext   = 32'(mem_rdata);
  assign cap_mask = 32'({MW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= acc && rq.load;
      idx_pipe[0] <= beat;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rq    <= '0;
      beat  <= '0;
      asm_q <= '0;
      mis_q <= 1'b0;
    end else begin
      if (cap) asm_q <= (asm_q & ~(cap_mask << cap_sh)) | (rd_ext << cap_sh);
      case (state)
        IDLE: if (req_valid) begin
          rq    <= '{load: req_load, size: req_size, uns: req_unsigned,
                     addr: req_addr, wdata: req_wdata, rd: req_rd};
          beat  <= '0;
          asm_q <= '0;
          mis_q <= mis_in;
          state <= mis_in ? DONE : ISSUE;
        end
        ISSUE: if (acc) begin
          if (last_beat) begin
            beat  <= '0;
            state <= rq.load ? WAIT : DONE;
          end else begin
            beat <= beat + 3'd1;
          end
        end
        WAIT: if (cap && idx_pipe[STAGES] == nb - 3'd1) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_sh  = 8'(beat) * 8'(MW);
  assign wshift = rq.wdata >> wr_sh;

  always_comb begin
    mem_wmask = '0;
    mem_wdata = '0;
    for (int j = 0; j < MEM_BYTES; j++) begin
      if (state == ISSUE && (int'(beat) * MEM_BYTES + j) < int'(sz)) begin
        mem_wmask[j]       = 1'b1;
        mem_wdata[8*j +: 8] = wshift[8*j +: 8];
      end
    end
  end

  always_comb begin
    case (rq.size)
      2'b00:   ext = rq.uns ? {24'd0, asm_q[7:0]}  : {{24{asm_q[7]}}, asm_q[7:0]};
      2'b01:   ext = rq.uns ? {16'd0, asm_q[15:0]} : {{16{asm_q[15]}}, asm_q[15:0]};
      default: ext = asm_q;
    endcase
  end

  assign mem_rw     = (state == ISSUE) ? (rq.load ? 2'b01 : 2'b10) : 2'b00;
  assign mem_addr   = (state == ISSUE) ? rq.addr + ADDR_W'(beat) * ADDR_W'(MEM_BYTES) : '0;
  assign req_ready  = (state == IDLE);
  assign stall_o    = (state != IDLE && state != DONE) || (state == IDLE && req_valid);
  assign resp_valid = done;
  assign resp_we    = done && rq.load && !mis_q && (rq.rd != 5'd0);
  assign resp_rd    = done ? rq.rd : 5'd0;
  assign resp_data  = (done && rq.load && !mis_q) ? ext : 32'd0;
endmodule
